// File: rtl/branch_resolve.sv
// branch_resolve: execute-stage branch resolution with a bimodal BHT.
// Decodes the branch condition, selects signed/unsigned compare, resolves
// taken/not-taken, trains 2-bit saturating counters and issues a registered
// one-cycle redirect/flush on a mispredict.
// Optional feature macro: BRANCH_STATS_EN (adds branch/mispredict counters
// and a synchronous stat_clear input).
module branch_resolve #(
    parameter int BHT_ENTRIES = 64,
    parameter int IDX_W       = $clog2(BHT_ENTRIES)
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef BRANCH_STATS_EN
    input  logic        stat_clear,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts,
`endif
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    input  logic        ex_valid,
    input  logic        ex_stall,
    input  logic        ex_is_branch,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    output logic        brun,
    input  logic        breq,
    input  logic        brlt,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush
);

    logic [1:0]       bht_r [BHT_ENTRIES];
    logic             redirect_valid_r;
    logic [31:0]      redirect_pc_r;

    logic [IDX_W-1:0] if_idx_s;
    logic [IDX_W-1:0] ex_idx_s;
    logic             taken_s;
    logic             legal_s;
    logic             resolve_s;
    logic             mispredict_s;
    logic [31:0]      next_pc_s;
    logic [1:0]       cnt_old_s;
    logic [1:0]       cnt_new_s;
    logic             unused_s;

    assign if_idx_s = if_pc[IDX_W+1:2];
    assign ex_idx_s = ex_pc[IDX_W+1:2];

    // Word-offset and upper fetch-PC bits do not participate in indexing.
    assign unused_s = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    // Prediction is the counter MSB; a same-cycle update is not yet visible.
    assign if_pred_taken = bht_r[if_idx_s][1];

    // funct3 bit 1 distinguishes BLTU/BGEU from the signed compares.
    assign brun = ex_funct3[1];

    // Decode the branch condition; 010/011 are not branches and never resolve.
    always_comb begin
        taken_s = 1'b0;
        legal_s = 1'b0;
        case (ex_funct3)
            3'b000:  begin taken_s = breq;  legal_s = 1'b1; end
            3'b001:  begin taken_s = !breq; legal_s = 1'b1; end
            3'b100:  begin taken_s = brlt;  legal_s = 1'b1; end
            3'b101:  begin taken_s = !brlt; legal_s = 1'b1; end
            3'b110:  begin taken_s = brlt;  legal_s = 1'b1; end
            3'b111:  begin taken_s = !brlt; legal_s = 1'b1; end
            default: begin taken_s = 1'b0;  legal_s = 1'b0; end
        endcase
    end

    // While a redirect is in flight, the EX instruction is wrong-path.
    assign resolve_s    = ex_valid && ex_is_branch && !ex_stall &&
                          !redirect_valid_r && legal_s;
    assign mispredict_s = resolve_s && (taken_s != ex_pred_taken);
    assign next_pc_s    = taken_s ? ex_target : (ex_pc + 32'd4);
    assign cnt_old_s    = bht_r[ex_idx_s];

    // Saturating 2-bit counter step toward the resolved direction.
    always_comb begin
        cnt_new_s = cnt_old_s;
        if (taken_s) begin
            if (cnt_old_s != 2'b11) begin
                cnt_new_s = cnt_old_s + 2'd1;
            end else begin
                cnt_new_s = 2'b11;
            end
        end else begin
            if (cnt_old_s != 2'b00) begin
                cnt_new_s = cnt_old_s - 2'd1;
            end else begin
                cnt_new_s = 2'b00;
            end
        end
    end

    // BHT training and the registered one-cycle redirect pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_r[i] <= 2'b01;
            end
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= 32'h0000_0000;
        end else begin
            redirect_valid_r <= mispredict_s;
            if (mispredict_s) begin
                redirect_pc_r <= next_pc_s;
            end
            if (resolve_s) begin
                bht_r[ex_idx_s] <= cnt_new_s;
            end
        end
    end

    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;
    assign flush          = redirect_valid_r;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches_r;
    logic [31:0] stat_mispredicts_r;

    // Event counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_branches_r    <= 32'd0;
            stat_mispredicts_r <= 32'd0;
        end else if (stat_clear) begin
            stat_branches_r    <= 32'd0;
            stat_mispredicts_r <= 32'd0;
        end else begin
            if (resolve_s) begin
                stat_branches_r <= stat_branches_r + 32'd1;
            end
            if (mispredict_s) begin
                stat_mispredicts_r <= stat_mispredicts_r + 32'd1;
            end
        end
    end

    assign stat_branches    = stat_branches_r;
    assign stat_mispredicts = stat_mispredicts_r;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: stimulus pushes expected redirect PCs,
// a monitor pops and compares whenever the DUT raises redirect_valid/flush.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic        ex_stall;
    logic        ex_is_branch;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic        brun;
    logic        breq;
    logic        brlt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
`ifdef BRANCH_STATS_EN
    logic        stat_clear;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    branch_resolve #(.BHT_ENTRIES(64)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
`ifdef BRANCH_STATS_EN
        .stat_clear       (stat_clear),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts),
`endif
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .ex_valid       (ex_valid),
        .ex_stall       (ex_stall),
        .ex_is_branch   (ex_is_branch),
        .ex_funct3      (ex_funct3),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .brun           (brun),
        .breq           (breq),
        .brlt           (brlt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every redirect cycle must match the oldest expected PC.
    always @(negedge clk) begin
        if (redirect_valid === 1'b1 || flush === 1'b1) begin
            chk("flush_eq_redirect", {31'd0, flush}, {31'd0, redirect_valid});
            if (exp_q.size() == 0) begin
                chk("unexpected_redirect", redirect_pc, 32'hDEAD_BEEF);
                if (redirect_pc == 32'hDEAD_BEEF) begin
                    n_err++;
                    $display("FAIL unexpected_redirect: got pulse expected none");
                end
            end else begin
                chk("redirect_pc", redirect_pc, exp_q.pop_front());
            end
        end
    end

    task automatic idle();
        ex_valid      = 1'b0;
        ex_stall      = 1'b0;
        ex_is_branch  = 1'b0;
        ex_funct3     = 3'b000;
        ex_pc         = 32'h0;
        ex_target     = 32'h0;
        ex_pred_taken = 1'b0;
        breq          = 1'b0;
        brlt          = 1'b0;
    endtask

    // Present one branch in EX for one cycle; push expected redirect if any.
    task automatic br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                      input logic pred, input logic eq, input logic lt, input logic stall,
                      input logic exp_redir, input logic [31:0] exp_pc);
        ex_valid      = 1'b1;
        ex_is_branch  = 1'b1;
        ex_stall      = stall;
        ex_funct3     = f3;
        ex_pc         = pc;
        ex_target     = tgt;
        ex_pred_taken = pred;
        breq          = eq;
        brlt          = lt;
        if (exp_redir) exp_q.push_back(exp_pc);
        #1;
        chk("brun", {31'd0, brun}, {31'd0, f3[1]});
        @(posedge clk); #1;
    endtask

    task automatic cyc(input int n);
        idle();
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pred(input string name, input logic [31:0] pc, input logic exp);
        if_pc = pc;
        #1;
        chk(name, {31'd0, if_pred_taken}, {31'd0, exp});
    endtask

    initial begin
        rst_n = 1'b0;
        if_pc = 32'h100;
        idle();
`ifdef BRANCH_STATS_EN
        stat_clear = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        rst_n = 1'b1;
        pred("rst_pred_100", 32'h100, 1'b0);
        for (int i = 0; i < 64; i++) pred("rst_pred_all", 32'(i) << 2, 1'b0);

        // BEQ taken, predicted not-taken; same-index read sees old value.
        if_pc = 32'h100;
        ex_valid = 1'b1;
        br(3'b000, 32'h100, 32'h140, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h140);
        cyc(2);
        pred("beq_trained", 32'h100, 1'b1);

        // Collision: resolve at idx 1 taken (01->10), fetch reads pre-update.
        if_pc = 32'h104;
        ex_valid = 1'b1; ex_is_branch = 1'b1; ex_funct3 = 3'b001; ex_pc = 32'h104;
        ex_target = 32'h0; ex_pred_taken = 1'b1; breq = 1'b0; brlt = 1'b0;
        #1;
        chk("collision_old", {31'd0, if_pred_taken}, 32'd0);
        @(posedge clk); #1;
        idle();
        pred("collision_new", 32'h104, 1'b1);

        // BLTU not taken, predicted taken at top of memory: wrap to 0.
        br(3'b110, 32'hFFFF_FFFC, 32'h1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000);
        cyc(2);
        // idx 63 now 00: not-taken stays 00, then one taken -> 01 (not taken).
        br(3'b101, 32'h0000_00FC, 32'h500, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        br(3'b100, 32'h0000_00FC, 32'h200, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200);
        cyc(2);
        pred("floor_sat", 32'hFC, 1'b0);

        // Four correctly predicted taken BNEs on idx 5 -> 11.
        for (int k = 0; k < 4; k++)
            br(3'b001, 32'h14, 32'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1);
        pred("sat_11", 32'h14, 1'b1);
        br(3'b001, 32'h14, 32'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h18);
        cyc(2);
        pred("sat_10", 32'h14, 1'b1);
        br(3'b001, 32'h14, 32'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h18);
        cyc(2);
        pred("sat_01", 32'h14, 1'b0);

        // Squash shadow: second branch right behind a mispredict is ignored.
        br(3'b000, 32'h28, 32'h300, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h300);
        br(3'b000, 32'h2C, 32'h400, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(2);
        pred("shadow_first", 32'h28, 1'b1);
        pred("shadow_second", 32'h2C, 1'b0);

        // Stalled mispredicting branch: no redirect, no update.
        br(3'b000, 32'h30, 32'h600, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        cyc(2);
        pred("stall_no_update", 32'h30, 1'b0);

        // Illegal funct3 010/011: no redirect, no update.
        br(3'b010, 32'h34, 32'h700, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        br(3'b011, 32'h34, 32'h700, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(2);
        pred("illegal_no_update", 32'h34, 1'b0);

        // BGEU taken (rs1 >= rs2 unsigned), predicted not-taken.
        br(3'b111, 32'h40, 32'h440, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h440);
        cyc(2);
        chk("pulse_done", {31'd0, redirect_valid}, 32'd0);

`ifdef BRANCH_STATS_EN
        stat_clear = 1'b1;
        @(posedge clk); #1;
        stat_clear = 1'b0;
        chk("stat_clr_br", stat_branches, 32'd0);
        chk("stat_clr_mp", stat_mispredicts, 32'd0);
        br(3'b000, 32'h50, 32'h900, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        br(3'b001, 32'h54, 32'h900, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        br(3'b100, 32'h58, 32'h900, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h900);
        cyc(2);
        chk("stat_branches", stat_branches, 32'd3);
        chk("stat_mispredicts", stat_mispredicts, 32'd1);
        stat_clear = 1'b1;
        br(3'b000, 32'h5C, 32'h990, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h990);
        stat_clear = 1'b0;
        chk("stat_clr_prio_br", stat_branches, 32'd0);
        chk("stat_clr_prio_mp", stat_mispredicts, 32'd0);
        cyc(2);
`endif

        // Reset on the edge that would register a mispredict cancels it.
        rst_n = 1'b0;
        br(3'b000, 32'h100, 32'h880, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        idle();
        chk("rst_cancel_redirect", {31'd0, redirect_valid}, 32'd0);
        rst_n = 1'b1;
        pred("rst_bht_reinit", 32'h100, 1'b0);
        cyc(3);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
